// File: rtl/kbd_matrix_scan_pkg.sv
// Shared keyboard matrix definitions: geometry, kbmat bit indexing and row drive encoding.
// kbmat bit for row r / column c is r*8+c; row i corresponds to blink address line ca[8+i].
// Scan state encoding for the two-state scan/coma controller.
package kbd_matrix_scan_pkg;

  localparam int KBD_ROWS = 8;
  localparam int KBD_COLS = 8;
  localparam int KBD_BITS = 64;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_COMA = 1'b1
  } scan_state_t;

  // Position of a key in the debounced image.
  function automatic int kbd_idx(input int r, input int c);
    return r * KBD_COLS + c;
  endfunction

  // Active-low one-hot drive pattern for a single row.
  function automatic logic [7:0] row_drive(input logic [2:0] r);
    return ~(8'b1 << r);
  endfunction

endpackage

// File: rtl/kbd_sync.sv
// Two-flop synchronizer for the asynchronous column sense lines.
// Latency: 2 clk cycles from pin to q.
// Resets to all ones so every column reads as released.
module kbd_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Metastability filter: first stage may resolve late, second stage is clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/kbd_matrix_scan.sv
// Z88 8x8 keyboard matrix scanner with whole-frame debounce and coma-mode wake detect.
// Latency: a change stable for DEBOUNCE_SCANS whole frames commits at the end of the last one.
// No backpressure: kbmat is a level, kbd_chg a single-cycle pulse on each commit.
module kbd_matrix_scan #(
  parameter int DIV            = 614,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        mck,
  input  logic        rin_n,
  input  logic        scan_en,
  input  logic [7:0]  col_n,
  output logic [7:0]  row_n,
  output logic [63:0] kbmat,
  output logic        kbd_chg,
  output logic        key_any,
  output logic        wake
);

  import kbd_matrix_scan_pkg::*;

  localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [3:0]    DB_MAX   = 4'(DEBOUNCE_SCANS);

  logic [7:0]          col_sync;
  logic [7:0]          cs;
  scan_state_t         state;
  logic [2:0]          row;
  logic [DW-1:0]       div;
  logic [KBD_BITS-1:0] raw;
  logic [KBD_BITS-1:0] prev;
  logic [3:0]          stable_cnt;
  logic [KBD_BITS-1:0] frame;
  logic [3:0]          cnt_nxt;
  logic                commit;

  kbd_sync #(.W(KBD_COLS)) u_sync (
    .clk   (mck),
    .rst_n (rin_n),
    .d     (col_n),
    .q     (col_sync)
  );

  // Closed keys pull their column low, so invert to get 1 = pressed.
  assign cs = ~col_sync;

  // Complete frame (row 7 spliced in from the live sample) and its debounce outcome.
  always_comb begin
    frame = raw;
    frame[KBD_BITS-KBD_COLS +: KBD_COLS] = cs;
    if (frame == prev) begin
      cnt_nxt = (stable_cnt >= DB_MAX) ? DB_MAX : stable_cnt + 4'd1;
    end else begin
      cnt_nxt = 4'd1;
    end
    commit = (cnt_nxt == DB_MAX) && (frame != kbmat);
  end

  // Scan/coma controller: row dwell timing, raw capture, frame debounce and commit.
  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      state      <= ST_SCAN;
      row_n      <= 8'hFF;
      row        <= 3'd0;
      div        <= '0;
      raw        <= '0;
      prev       <= '0;
      stable_cnt <= 4'd0;
      kbmat      <= '0;
      kbd_chg    <= 1'b0;
      key_any    <= 1'b0;
      wake       <= 1'b0;
    end else begin
      kbd_chg <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (!scan_en) begin
            // Abandon the partial frame; kbmat and key_any keep their last value.
            state      <= ST_COMA;
            row_n      <= 8'h00;
            row        <= 3'd0;
            div        <= '0;
            stable_cnt <= 4'd0;
          end else if (div == DIV_LAST) begin
            div                                <= '0;
            row                                <= row + 3'd1;
            row_n                              <= row_drive(row + 3'd1);
            raw[kbd_idx(int'(row), 0) +: 8]    <= cs;
            if (row == 3'd7) begin
              stable_cnt <= cnt_nxt;
              prev       <= frame;
              if (commit) begin
                kbmat   <= frame;
                key_any <= |frame;
                kbd_chg <= 1'b1;
              end
            end
          end else begin
            div   <= div + 1'b1;
            row_n <= row_drive(row);
          end
        end
        ST_COMA: begin
          // All rows driven: any closed key shows up on some column.
          row_n <= 8'h00;
          wake  <= |cs;
          if (scan_en) begin
            // prev is kept so the first frame is compared with the last pre-coma frame.
            state <= ST_SCAN;
            row_n <= row_drive(3'd0);
            row   <= 3'd0;
            div   <= '0;
            wake  <= 1'b0;
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_matrix_scan.sv
// Bench for kbd_matrix_scan: directed scenarios plus randomized key sequences.
// Expected kbmat/kbd_chg come from a frame-history model of the debounce rule.
// Matrix is modelled as ideal switches between driven rows and pulled-up columns.
module tb_kbd_matrix_scan;

  localparam int DIV = 4;
  localparam int DB  = 3;
  localparam logic [63:0] K25 = 64'h0000_0000_0020_0000;
  localparam logic [63:0] K61 = 64'h0002_0000_0000_0000;
  localparam logic [63:0] K6  = 64'h8000_0000_0000_0001;

  logic        mck     = 1'b0;
  logic        rin_n   = 1'b1;
  logic        scan_en = 1'b1;
  logic [7:0]  col_n;
  logic [7:0]  row_n;
  logic [63:0] kbmat;
  logic        kbd_chg;
  logic        key_any;
  logic        wake;

  logic [63:0] keys = '0;
  int          tests = 0;
  int          fails = 0;
  int          chg_pulses = 0;
  int          m_commits = 0;
  logic [63:0] m_kbmat = '0;
  logic [63:0] hist[$];

  kbd_matrix_scan #(.DIV(DIV), .DEBOUNCE_SCANS(DB)) dut (
    .mck     (mck),
    .rin_n   (rin_n),
    .scan_en (scan_en),
    .col_n   (col_n),
    .row_n   (row_n),
    .kbmat   (kbmat),
    .kbd_chg (kbd_chg),
    .key_any (key_any),
    .wake    (wake)
  );

  always #5 mck = ~mck;

  // Switch matrix: a column reads low when a closed key sits on a driven row.
  always_comb begin
    col_n = 8'hFF;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (keys[r*8+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  // Count every cycle kbd_chg is high.
  always @(posedge mck) if (kbd_chg === 1'b1) chg_pulses++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_row(input int r);
    logic [7:0] pat;
    bit         found;
    pat   = ~(8'b1 << r);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (row_n === pat) found = 1'b1;
      else @(negedge mck);
    end
    if (!found) check("row_timeout", 64'(row_n), 64'(pat));
  endtask

  // Drive one full frame; row brow sees bimg instead of img. Checks outputs at the next frame start.
  task automatic run_frame(input logic [63:0] img, input int brow, input logic [63:0] bimg,
                           input string tag);
    logic [63:0] fimg;
    int          run;
    logic        exp_chg;
    fimg = img;
    for (int r = 0; r < 8; r++) begin
      wait_row(r);
      keys = (r == brow) ? bimg : img;
      if (r == brow) fimg[r*8 +: 8] = bimg[r*8 +: 8];
    end
    wait_row(0);
    hist.push_back(fimg);
    run = 0;
    for (int i = int'(hist.size()) - 1; i >= 0; i--) begin
      if (hist[i] != fimg) break;
      run++;
    end
    exp_chg = (run >= DB) && (fimg != m_kbmat);
    if (exp_chg) begin
      m_kbmat = fimg;
      m_commits++;
    end
    check({tag, "_kbmat"}, kbmat, m_kbmat);
    check({tag, "_chg"}, 64'(kbd_chg), 64'(exp_chg));
    check({tag, "_any"}, 64'(key_any), 64'(|m_kbmat));
  endtask

  task automatic chk_pulses(input string tag, input int p0, input int exp);
    @(posedge mck);
    #1;
    check(tag, 64'(chg_pulses - p0), 64'(exp));
  endtask

  function automatic logic [63:0] rand_img();
    logic [63:0] v;
    int          n;
    v = '0;
    n = $urandom_range(0, 3);
    for (int k = 0; k < n; k++) v[$urandom_range(0, 63)] = 1'b1;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int c0;
    logic [63:0] img;
    int nf;

    // Power-on reset values
    #2 rin_n = 1'b0;
    #10;
    check("rst_row_n", 64'(row_n), 64'hFF);
    check("rst_kbmat", kbmat, 64'h0);
    check("rst_chg", 64'(kbd_chg), 64'h0);
    check("rst_any", 64'(key_any), 64'h0);
    check("rst_wake", 64'(wake), 64'h0);
    @(negedge mck) rin_n = 1'b1;
    @(posedge mck);
    #1 check("rst_first_row", 64'(row_n), 64'hFE);

    // Single key row2/col5 held from frame start
    p0 = chg_pulses;
    repeat (3) run_frame(K25, -1, '0, "t2");
    check("t2_const", kbmat, K25);
    run_frame(K25, -1, '0, "t2_hold");
    chk_pulses("t2_pulses", p0, 1);

    // Release after commit
    p0 = chg_pulses;
    repeat (3) run_frame('0, -1, '0, "t4");
    check("t4_const", kbmat, 64'h0);
    run_frame('0, -1, '0, "t4_hold");
    chk_pulses("t4_pulses", p0, 1);

    // Bounce: key opens for the row 2 dwell of the second frame
    p0 = chg_pulses;
    run_frame(K25, -1, '0, "t3_f1");
    run_frame(K25, 2, '0, "t3_bounce");
    run_frame(K25, -1, '0, "t3_f3");
    run_frame(K25, -1, '0, "t3_f4");
    check("t3_not_yet", kbmat, 64'h0);
    run_frame(K25, -1, '0, "t3_f5");
    check("t3_const", kbmat, K25);
    chk_pulses("t3_pulses", p0, 1);

    // Two corner keys change in the same frame
    p0 = chg_pulses;
    repeat (3) run_frame(K6, -1, '0, "t6");
    check("t6_const", kbmat, K6);
    chk_pulses("t6_pulses", p0, 1);

    // Asynchronous reset mid-scan with keys held
    wait_row(3);
    #2 rin_n = 1'b0;
    #1;
    check("t1_row_n", 64'(row_n), 64'hFF);
    check("t1_kbmat", kbmat, 64'h0);
    check("t1_chg", 64'(kbd_chg), 64'h0);
    check("t1_any", 64'(key_any), 64'h0);
    hist.delete();
    m_kbmat = '0;
    keys = '0;
    @(negedge mck) rin_n = 1'b1;
    @(posedge mck);
    #1 check("t1_first_row", 64'(row_n), 64'hFE);

    // Randomized key sequences, occasional single-row bounce
    p0 = chg_pulses;
    c0 = m_commits;
    for (int s = 0; s < 15; s++) begin
      img = rand_img();
      nf  = $urandom_range(1, 5);
      for (int f = 0; f < nf; f++) begin
        if ($urandom_range(0, 3) == 0)
          run_frame(img, $urandom_range(0, 7), rand_img(), "rnd");
        else
          run_frame(img, -1, '0, "rnd");
      end
    end
    chk_pulses("rnd_pulses", p0, m_commits - c0);

    // Coma mode entered mid-frame with a row 6 key held
    p0 = chg_pulses;
    c0 = m_commits;
    repeat (3) run_frame(K61, -1, '0, "t5_pre");
    check("t5_pre_const", kbmat, K61);
    wait_row(3);
    scan_en = 1'b0;
    @(negedge mck);
    check("t5_row_n", 64'(row_n), 64'h00);
    check("t5_kbmat_held", kbmat, K61);
    hist.delete();
    repeat (3) @(negedge mck);
    check("t5_wake_on", 64'(wake), 64'h1);
    keys = '0;
    repeat (4) @(negedge mck);
    check("t5_wake_off", 64'(wake), 64'h0);
    check("t5_row_n_hold", 64'(row_n), 64'h00);
    check("t5_any_held", 64'(key_any), 64'h1);
    scan_en = 1'b1;
    @(negedge mck);
    check("t5_exit_row", 64'(row_n), 64'hFE);
    check("t5_exit_wake", 64'(wake), 64'h0);
    repeat (3) run_frame('0, -1, '0, "t5_post");
    check("t5_post_const", kbmat, 64'h0);
    chk_pulses("t5_pulses", p0, m_commits - c0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
